// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, instruction field positions and
// the major opcodes recognised by decode.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Bit positions of the fixed instruction fields.
  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_MSB = 6;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned F3_MSB  = 14;
  localparam int unsigned F7_LSB  = 25;
  localparam int unsigned F7_MSB  = 31;

  // Major opcodes consumed by the decode/control unit.
  typedef enum logic [6:0] {
    OPC_R      = 7'b0110011,
    OPC_I      = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011
  } opcode_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous in-order FIFO with flush. Push and pop may coincide at
// any occupancy; a push into a full FIFO is accepted only alongside a pop.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [WIDTH-1:0]             data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_fire;
  logic             pop_fire;

  // Pointer increment that wraps at DEPTH, so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign pop_fire  = pop_i && !empty_o;
  assign push_fire = push_i && !flush_i && (!full_o || pop_fire);

  // Pointer and occupancy bookkeeping; flush discards every entry at once.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_fire) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_fire)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
    end
  end

  // Entry storage write port.
  // NOTE: storage is deliberately not reset; validity is tracked by count_q,
  // so stale contents are never observed and the array maps to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited word reads to
// instruction memory, buffers responses in order and hands them to decode.
// A branch redirect flushes the buffer and marks in-flight reads as stale.
module instr_fetch
  import core_pkg::*;
#(
  parameter int unsigned       XLEN       = core_pkg::XLEN,
  parameter logic [XLEN-1:0]   RESET_PC   = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  // Fetch state.
  logic            req_en_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] fetch_pc_d;
  logic [CNT_W-1:0] discard_q;
  logic [CNT_W-1:0] discard_d;

  // Instruction buffer ({instr, pc} per entry).
  logic              fifo_push;
  logic              fifo_pop;
  logic [2*XLEN-1:0] fifo_wdata;
  logic [2*XLEN-1:0] fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  // PC queue: one entry per in-flight read, so its occupancy is the
  // outstanding count and its head is the PC of the next response.
  logic [XLEN-1:0]   pcq_head;
  logic [CNT_W-1:0]  outstanding;
  logic              pcq_full;
  logic              pcq_empty;

  logic [CNT_W:0]    inflight;
  logic              credit_ok;
  logic              req_raw;
  logic              gnt_fire;
  logic              drop_rsp;
  logic              unused_redirect_lsbs;

  // Credit: buffered plus in-flight words never exceed the buffer depth, so a
  // response always has a slot waiting for it.
  assign inflight  = {1'b0, fifo_count} + {1'b0, outstanding};
  assign credit_ok = (inflight < (CNT_W+1)'(FIFO_DEPTH));
  assign req_raw   = req_en_q && credit_ok;
  assign imem_req  = req_raw && !redirect_valid;
  assign imem_addr = fetch_pc_q;

  // A grant seen in a redirect cycle answers the request imem observed on the
  // credit alone; it is counted so that its response is later discarded.
  assign gnt_fire  = imem_gnt && req_raw;

  // Responses are dropped while stale reads from before a redirect drain.
  assign drop_rsp   = imem_rvalid && (discard_q != '0);
  assign fifo_push  = imem_rvalid && !drop_rsp;
  assign fifo_wdata = {imem_rdata, pcq_head};
  assign fifo_pop   = id_valid && id_ready;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2*XLEN)
  ) u_instr_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .flush_i (redirect_valid),
    .data_o  (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XLEN)
  ) u_pc_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (gnt_fire),
    .data_i  (fetch_pc_q),
    .pop_i   (imem_rvalid),
    .flush_i (1'b0),
    .data_o  (pcq_head),
    .count_o (outstanding),
    .full_o  (pcq_full),
    .empty_o (pcq_empty)
  );

  // Next fetch PC and stale-response count.
  // NOTE: every variable assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      // Everything still in flight after this edge belongs to the old path.
      // A response arriving now is retired here (dropped or flushed).
      discard_d  = CNT_W'({1'b0, outstanding} + (CNT_W+1)'(gnt_fire)
                          - (CNT_W+1)'(imem_rvalid));
    end else begin
      if (gnt_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (drop_rsp) discard_d  = discard_q - CNT_W'(1);
    end
  end

  // Fetch state registers; requests are enabled from the first edge after
  // reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_en_q   <= 1'b0;
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      req_en_q   <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      // Credit makes these impossible; they flag a broken imem or credit bug.
      assert (!(fifo_push && fifo_full && !fifo_pop && !redirect_valid));
      assert (!(imem_rvalid && pcq_empty));
      assert (!(gnt_fire && pcq_full && !imem_rvalid));
    end
  end

  // Decode-facing view of the buffer head.
  assign id_valid  = !fifo_empty;
  assign id_instr  = fifo_rdata[2*XLEN-1:XLEN];
  assign id_pc     = fifo_rdata[XLEN-1:0];
  assign id_opcode = id_instr[OPC_MSB:OPC_LSB];
  assign id_funct3 = id_instr[F3_MSB:F3_LSB];
  assign id_funct7 = id_instr[F7_MSB:F7_LSB];

endmodule
